shift_add_mult: RTL

SHIFT_ADD_MULT -- requirements
Module: shift_add_mult

---
 rtl/pkg_system_mdr.sv | 20 ++
 rtl/mult_shift_reg.sv | 41 ++++
 rtl/shift_add_mult.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/pkg_system_mdr.sv
// Shared types and constants for the shift-add multiplier slice.
package pkg_system_mdr;

   localparam int unsigned DEFAULT_SDW = 32;

   typedef logic [DEFAULT_SDW-1:0] data_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_CALC = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   typedef enum logic {
      DIR_LEFT  = 1'b0,
      DIR_RIGHT = 1'b1
   } shift_dir_e;

endpackage : pkg_system_mdr

// File: rtl/mult_shift_reg.sv
// Loadable shift register with shift enable; load wins over shift.
// OUT_W exposes only the low bits that the consumer actually needs.
module mult_shift_reg
   import pkg_system_mdr::*;
#(
   parameter int unsigned W     = 32,
   parameter shift_dir_e  DIR   = DIR_LEFT,
   parameter int unsigned SHIFT = 1,
   parameter int unsigned OUT_W = W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic [W-1:0]     i_load_val,
   input  logic             i_shift_en,
   output logic [OUT_W-1:0] o_val
);

   logic [W-1:0] val_d;
   logic [W-1:0] val_q;

   always_comb begin
      val_d = val_q;
      if (i_load) begin
         val_d = i_load_val;
      end else if (i_shift_en) begin
         val_d = (DIR == DIR_LEFT) ? (val_q << SHIFT) : (val_q >> SHIFT);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         val_q <= '0;
      end else begin
         val_q <= val_d;
      end
   end

   assign o_val = val_q[OUT_W-1:0];

endmodule : mult_shift_reg

// File: rtl/shift_add_mult.sv
// Sequential shift-and-add multiplier, fixed SDW+2 cycle latency.
// Define SIGNED_MULT_EN for two's-complement operands (sign/magnitude around the core).
module shift_add_mult
   import pkg_system_mdr::*;
#(
   parameter int unsigned SDW = DEFAULT_SDW
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           i_start,
   input  logic [SDW-1:0] i_multiplicand,
   input  logic [SDW-1:0] i_multiplier,
   output logic [SDW-1:0] o_product,
   output logic           o_overflow,
   output logic           o_busy,
   output logic           o_done
);

   localparam int unsigned AW    = 2 * SDW;
   localparam int unsigned CNT_W = $clog2(SDW) + 1;

   state_e           state_d, state_q;
   logic [SDW-1:0]   a_d, a_q;
   logic [SDW-1:0]   b_d, b_q;
   logic [AW-1:0]    acc_d, acc_q;
   logic [CNT_W-1:0] cnt_d, cnt_q;
   logic [SDW-1:0]   product_d, product_q;
   logic             ovf_d, ovf_q;
   logic             busy_d, busy_q;
   logic             done_d, done_q;

   logic             sr_load;
   logic             sr_shift_en;
   logic [AW-1:0]    mcand_val;
   logic             mplier_lsb;

   logic [SDW-1:0]   a_mag_c;
   logic [SDW-1:0]   b_mag_c;
   logic [AW-1:0]    acc_sum_c;
   logic [AW-1:0]    result_c;
   logic             ovf_c;

   mult_shift_reg #(
      .W     (AW),
      .DIR   (DIR_LEFT),
      .SHIFT (1),
      .OUT_W (AW)
   ) u_mcand_sr (
      .clk        (clk),
      .rst        (rst),
      .i_load     (sr_load),
      .i_load_val ({{SDW{1'b0}}, a_mag_c}),
      .i_shift_en (sr_shift_en),
      .o_val      (mcand_val)
   );

   mult_shift_reg #(
      .W     (SDW),
      .DIR   (DIR_RIGHT),
      .SHIFT (1),
      .OUT_W (1)
   ) u_mplier_sr (
      .clk        (clk),
      .rst        (rst),
      .i_load     (sr_load),
      .i_load_val (b_mag_c),
      .i_shift_en (sr_shift_en),
      .o_val      (mplier_lsb)
   );

   // Partial-product accumulate for the current CALC step.
   always_comb begin
      acc_sum_c = mplier_lsb ? (acc_q + mcand_val) : acc_q;
   end

`ifdef SIGNED_MULT_EN
   logic neg_c;

   // Magnitudes into the core, sign restored on the final sum.
   always_comb begin
      neg_c    = a_q[SDW-1] ^ b_q[SDW-1];
      a_mag_c  = a_q[SDW-1] ? ((~a_q) + SDW'(1)) : a_q;
      b_mag_c  = b_q[SDW-1] ? ((~b_q) + SDW'(1)) : b_q;
      result_c = neg_c ? ((~acc_sum_c) + AW'(1)) : acc_sum_c;
      ovf_c    = !((&result_c[AW-1:SDW-1]) || !(|result_c[AW-1:SDW-1]));
   end
`else
   always_comb begin
      a_mag_c  = a_q;
      b_mag_c  = b_q;
      result_c = acc_sum_c;
      ovf_c    = |acc_sum_c[AW-1:SDW];
   end
`endif

   // Next-state and datapath control.
   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      product_d   = product_q;
      ovf_d       = ovf_q;
      done_d      = 1'b0;
      sr_load     = 1'b0;
      sr_shift_en = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (i_start) begin
               a_d     = i_multiplicand;
               b_d     = i_multiplier;
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            acc_d   = '0;
            cnt_d   = '0;
            sr_load = 1'b1;
            state_d = ST_CALC;
         end
         ST_CALC: begin
            acc_d       = acc_sum_c;
            sr_shift_en = 1'b1;
            cnt_d       = cnt_q + CNT_W'(1);
            // Final step: publish result so o_done and o_product appear in DONE.
            if (cnt_q == CNT_W'(SDW - 1)) begin
               product_d = result_c[SDW-1:0];
               ovf_d     = ovf_c;
               done_d    = 1'b1;
               state_d   = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         a_q       <= '0;
         b_q       <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         product_q <= '0;
         ovf_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         b_q       <= b_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         product_q <= product_d;
         ovf_q     <= ovf_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign o_product  = product_q;
   assign o_overflow = ovf_q;
   assign o_busy     = busy_q;
   assign o_done     = done_q;

endmodule : shift_add_mult
